// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared game constants: coordinate width, play-field bounds, enemy count
// and the coordinate type used by the shot engine.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int COORD_W      = 10;
    localparam int FIELD_TOP    = 8;
    localparam int FIELD_BOTTOM = 472;
    localparam int FIELD_RIGHT  = 432;
    localparam int NUM_ENEMIES  = 4;

    // Bullets appear this many pixels above the player's reference point.
    localparam int SPAWN_OFS    = 12;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/shot_slot.sv
// ---------------------------------------------------------------------------
// shot_slot
// One bullet slot.
// Each tick a valid bullet is first checked for a hit, then for leaving the
// top of the field, and otherwise it moves up by SPEED.
//
// Ports:
//   clk22, rst (async, active-low), gamestart (sync clear)
//   spawn, spawn_x, spawn_y : load a new bullet (slot must be free)
//   enm_x, enm_y, enm_alive : enemy positions / alive flags
//   vld, x, y               : registered slot state
//   hit                     : one-hot (lowest index) enemy struck this tick
// ---------------------------------------------------------------------------
module shot_slot
    import game_pkg::*;
#(
    parameter int SPEED    = 10,
    parameter int HALF_BOX = 12
) (
    input  logic                   clk22,
    input  logic                   rst,
    input  logic                   gamestart,
    input  logic                   spawn,
    input  coord_t                 spawn_x,
    input  coord_t                 spawn_y,
    input  coord_t [NUM_ENEMIES-1:0] enm_x,
    input  coord_t [NUM_ENEMIES-1:0] enm_y,
    input  logic [NUM_ENEMIES-1:0] enm_alive,
    output logic                   vld,
    output coord_t                 x,
    output coord_t                 y,
    output logic [NUM_ENEMIES-1:0] hit
);

    localparam logic [COORD_W:0] HB       = HALF_BOX[COORD_W:0];
    localparam coord_t           RETIRE_Y = coord_t'(FIELD_TOP + SPEED);
    localparam coord_t           STEP     = coord_t'(SPEED);

    logic   vld_p0;
    coord_t x_p0;
    coord_t y_p0;

    // One extra bit so the difference of two 10-bit coordinates never wraps.
    function automatic logic [COORD_W:0] abs_diff(input coord_t a, input coord_t b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        abs_diff = (d < 0) ? -d : d;
    endfunction

    logic [NUM_ENEMIES-1:0] overlap;
    logic                   found;

    always_comb begin
        overlap = '0;
        hit     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_ENEMIES; k++) begin
            overlap[k] = enm_alive[k]
                      && (abs_diff(x_p0, enm_x[k]) < HB)
                      && (abs_diff(y_p0, enm_y[k]) < HB);
        end
        // Only the lowest-index overlapping enemy takes the hit.
        for (int k = 0; k < NUM_ENEMIES; k++) begin
            if (vld_p0 && overlap[k] && !found) begin
                hit[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    // ---- stage p0: slot state register ----
    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            x_p0   <= '0;
            y_p0   <= '0;
        end else if (gamestart) begin
            vld_p0 <= 1'b0;
            x_p0   <= '0;
            y_p0   <= '0;
        end else if (spawn) begin
            vld_p0 <= 1'b1;
            x_p0   <= spawn_x;
            y_p0   <= spawn_y;
        end else if (vld_p0) begin
            if (found || (y_p0 < RETIRE_Y)) begin
                vld_p0 <= 1'b0;
            end else begin
                y_p0 <= y_p0 - STEP;
            end
        end
    end

    assign vld = vld_p0;
    assign x   = x_p0;
    assign y   = y_p0;

endmodule

// File: rtl/reimu_bullet.sv
// ---------------------------------------------------------------------------
// reimu_bullet
// Player shot engine.
// It spawns bullets from Reimu's position while fire is held, moves them up
// once per clk22 tick, and pulses enm_hit for each enemy struck.
//
// Ports:
//   clk22, rst (async, active-low), gamestart (sync clear)
//   fire, reimux, reimuy             : fire button and player position
//   enmx1..4, enmy1..4, enm1..4      : enemy positions and alive flags
//   bullet_vld/bullet_x/bullet_y     : per-slot state; slot i uses [10i+9:10i]
//   enm_hit                          : one-tick hit pulse per enemy
//   hit_cnt                          : saturating hit total; this port exists
//                                      only when REIMU_BULLET_HITCNT_EN is
//                                      defined
// ---------------------------------------------------------------------------
module reimu_bullet
    import game_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 10,
    parameter int COOLDOWN    = 6,
    parameter int HALF_BOX    = 12
) (
    input  logic                           clk22,
    input  logic                           rst,
    input  logic                           gamestart,
    input  logic                           fire,
    input  logic [COORD_W-1:0]             reimux,
    input  logic [COORD_W-1:0]             reimuy,
    input  logic [COORD_W-1:0]             enmx1,
    input  logic [COORD_W-1:0]             enmx2,
    input  logic [COORD_W-1:0]             enmx3,
    input  logic [COORD_W-1:0]             enmx4,
    input  logic [COORD_W-1:0]             enmy1,
    input  logic [COORD_W-1:0]             enmy2,
    input  logic [COORD_W-1:0]             enmy3,
    input  logic [COORD_W-1:0]             enmy4,
    input  logic                           enm1,
    input  logic                           enm2,
    input  logic                           enm3,
    input  logic                           enm4,
    output logic [NUM_BULLETS-1:0]         bullet_vld,
    output logic [COORD_W*NUM_BULLETS-1:0] bullet_x,
    output logic [COORD_W*NUM_BULLETS-1:0] bullet_y,
    output logic [NUM_ENEMIES-1:0]         enm_hit
`ifdef REIMU_BULLET_HITCNT_EN
    ,
    output logic [7:0]                     hit_cnt
`endif
);

    localparam int     CD_W        = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam coord_t SPAWN_MIN_Y = coord_t'(SPAWN_OFS + FIELD_TOP + SPEED);
    localparam coord_t SPAWN_DY    = coord_t'(SPAWN_OFS);

    coord_t [NUM_ENEMIES-1:0] enm_x;
    coord_t [NUM_ENEMIES-1:0] enm_y;
    logic   [NUM_ENEMIES-1:0] enm_alive;

    assign enm_x     = {enmx4, enmx3, enmx2, enmx1};
    assign enm_y     = {enmy4, enmy3, enmy2, enmy1};
    assign enm_alive = {enm4, enm3, enm2, enm1};

    logic [CD_W-1:0]        cd_p0;
    logic [NUM_ENEMIES-1:0] enm_hit_p0;
    logic [NUM_BULLETS-1:0] spawn_sel;
    logic                   slot_free;
    logic                   spawn_ok;
    logic [NUM_ENEMIES-1:0] slot_hit [NUM_BULLETS];
    logic [NUM_ENEMIES-1:0] hit_or;

    // The allocator looks at the registered valid vector.
    // A slot freed this tick therefore becomes usable only on the next tick.
    always_comb begin
        spawn_sel = '0;
        slot_free = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!bullet_vld[i] && !slot_free) begin
                spawn_sel[i] = 1'b1;
                slot_free    = 1'b1;
            end
        end
        spawn_ok = fire && (cd_p0 == '0) && slot_free && (reimuy >= SPAWN_MIN_Y);
    end

    for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
        shot_slot #(
            .SPEED    (SPEED),
            .HALF_BOX (HALF_BOX)
        ) u_slot (
            .clk22     (clk22),
            .rst       (rst),
            .gamestart (gamestart),
            .spawn     (spawn_ok && spawn_sel[i]),
            .spawn_x   (reimux),
            .spawn_y   (reimuy - SPAWN_DY),
            .enm_x     (enm_x),
            .enm_y     (enm_y),
            .enm_alive (enm_alive),
            .vld       (bullet_vld[i]),
            .x         (bullet_x[COORD_W*i +: COORD_W]),
            .y         (bullet_y[COORD_W*i +: COORD_W]),
            .hit       (slot_hit[i])
        );
    end

    always_comb begin
        hit_or = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            hit_or = hit_or | slot_hit[i];
        end
    end

    // ---- stage p0: cooldown and hit pulse registers ----
    // A dropped shot leaves cd at 0, so the shot fires as soon as it is allowed.
    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            cd_p0      <= '0;
            enm_hit_p0 <= '0;
        end else if (gamestart) begin
            cd_p0      <= '0;
            enm_hit_p0 <= '0;
        end else begin
            enm_hit_p0 <= hit_or;
            if (spawn_ok) begin
                cd_p0 <= CD_W'(COOLDOWN - 1);
            end else if (cd_p0 != '0) begin
                cd_p0 <= cd_p0 - 1'b1;
            end
        end
    end

    assign enm_hit = enm_hit_p0;

`ifdef REIMU_BULLET_HITCNT_EN
    function automatic logic [2:0] popcount4(input logic [NUM_ENEMIES-1:0] v);
        popcount4 = '0;
        for (int k = 0; k < NUM_ENEMIES; k++) begin
            popcount4 = popcount4 + {2'b00, v[k]};
        end
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, b};
        sat_add8 = s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [7:0] hit_cnt_p0;

    always_ff @(posedge clk22 or negedge rst) begin
        if (!rst) begin
            hit_cnt_p0 <= '0;
        end else if (gamestart) begin
            hit_cnt_p0 <= '0;
        end else begin
            hit_cnt_p0 <= sat_add8(hit_cnt_p0, popcount4(hit_or));
        end
    end

    assign hit_cnt = hit_cnt_p0;
`endif

endmodule
